tnn_feature_encoder: RTL and testbench
======================================

# tnn_feature_encoder

Streaming front end for the 8-feature, 2-bit-per-feature TNN classifier cores. It accepts raw unsigned feature samples one per beat over a valid/ready stream and quantizes each to a 2-bit code against per-feature thresholds. It then packs the eight codes into the 16-bit operand bus the classifier consumes (feature 0 → `input_a` … feature 7 → `input_h`) and presents that bus with a valid/ready handshake.

## Interface
Parameters:
- `FEAT_W`, 8: raw feature width, in bits.
- `N_FEAT`, 8: number of features per vector. Fixed at 8 to match the classifier operand set.
- `THRESH`, {8{8'd192,8'd128,8'd64}}: packed thresholds, `3*FEAT_W` bits per feature, feature 0 in the LSBs. Within each feature, fields are T0 (low), T1, T2 (high). Thresholds must satisfy T0 ≤ T1 ≤ T2.

Ports:
- `clk`, input, 1: the only clock. All state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `s_valid`, input, 1: a raw feature beat is present.
- `s_ready`, output, 1: the block accepts a beat this cycle.
- `s_data`, input, `FEAT_W`: raw unsigned feature value.
- `s_last`, input, 1: marks the final beat of a vector.
- `m_valid`, output, 1: the packed vector is valid.
- `m_ready`, input, 1: downstream accepts the vector.
- `m_data`, output, `2*N_FEAT`: feature i code on bits [2i+1:2i].
- `err_len`, output, 1: one-cycle pulse when a malformed vector is detected.

## Operation
- Beat transfer occurs when `s_valid` and `s_ready` are both high. Vector transfer occurs when `m_valid` and `m_ready` are both high.
- Quantization: code = (x≥T0) + (x≥T1) + (x≥T2), giving a value in 0..3. Comparisons are unsigned and full `FEAT_W` width. Each code is computed at beat acceptance and written into slot idx.
- idx is a 3-bit beat counter, reset to 0.
- The state machine has three states: COLLECT (reset state), HOLD and RESYNC.
  - **COLLECT:**
    - `s_ready`=1.
    - An accepted beat with idx<7 and `s_last`=0 stores the code and increments idx.
    - An accepted beat with idx<7 and `s_last`=1 is a short vector. The partial vector is discarded, idx is set to 0, `err_len` pulses and the state stays COLLECT.
    - An accepted beat with idx=7 and `s_last`=1 stores the code, sets idx to 0 and moves to HOLD.
    - An accepted beat with idx=7 and `s_last`=0 is a long vector. The vector is discarded, `err_len` pulses, idx is set to 0 and the state moves to RESYNC.
  - **HOLD:**
    - `s_ready`=0 and `m_valid`=1.
    - `m_data` is stable until transfer.
    - On transfer, the state moves to COLLECT.
  - **RESYNC:**
    - `s_ready`=1.
    - Accepted beats are dropped.
    - A beat with `s_last`=1 moves the state to COLLECT with idx=0. No further `err_len` pulse is issued.
- Reset values: `s_ready`=0 while `rst` is high and 1 from the first cycle after deassertion. `m_valid`=0, `m_data`=0, `err_len`=0, idx=0, state=COLLECT.
- Reset asserted mid-vector or in HOLD discards all data immediately. No partial vector is ever emitted.

## Timing
- `m_valid` rises on the clock edge that accepts the 8th beat. It is observed in the following cycle, giving 1 cycle of latency from the last beat.
- The minimum period between vectors is 9 cycles: 8 beats plus 1 HOLD cycle with `m_ready` tied high.
- `s_ready` is a registered function of state only and has no combinational path from `m_ready`. It rises the cycle after the vector transfer.
- `err_len` is registered and is high for exactly the one cycle after the offending beat is accepted.
- `m_data` bits not yet written in COLLECT hold their previous values but are never observable, because `m_valid` is 0 during COLLECT.

## Configuration
- `TNN_ENC_ERRCNT_EN`:
  - Defined: adds an output port `err_cnt` [7:0]. It resets to 0, increments on every `err_len` pulse and saturates at 255.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Quantization and packing:** default thresholds, beats 0,63,64,127,128,191,192,255 with `s_last` on beat 8 and `m_ready`=1 → `m_data`=0xFA50, `m_valid` high for one cycle, 1 cycle after beat 8.
- **Backpressure:** same vector with `m_ready`=0 for 5 cycles → `m_valid` and `m_data`=0xFA50 held, `s_ready`=0 throughout. After `m_ready`=1, `s_ready`=1 on the next cycle.
- **Short vector:** 3 beats with `s_last` on the 3rd → `err_len` pulse, no `m_valid`. The next 8 beats of value 255 give `m_data`=0xFFFF.
- **Long vector:** 10 beats with `s_last` on the 10th → `err_len` pulse once, after beat 8. Beats 9–10 are dropped and no vector is emitted. The next valid vector is emitted normally.
- **Reset mid-operation:** `rst` asserted after 5 beats, or during HOLD → `m_valid`=0 and `m_data`=0 asynchronously. The next full vector packs correctly from idx 0.
- **With `TNN_ENC_ERRCNT_EN`:** 300 short vectors → `err_cnt`=255.

Source files
------------

// File: rtl/tnn_feature_encoder.sv
// Streaming quantizer/packer: eight raw feature beats become one 16-bit 2-bit-code operand vector.
// Optional macro TNN_ENC_ERRCNT_EN adds a saturating malformed-vector counter port err_cnt.
module tnn_feature_encoder #(
  parameter int FEAT_W = 8,
  parameter int N_FEAT = 8,
  parameter logic [3*FEAT_W*N_FEAT-1:0] THRESH = {8{8'd192, 8'd128, 8'd64}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [FEAT_W-1:0]   s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*N_FEAT-1:0] m_data,
  output logic                err_len
`ifdef TNN_ENC_ERRCNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int TW = 3 * FEAT_W;

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    RESYNC
  } state_t;

  state_t state, state_next;
  logic [2:0] idx, idx_next;
  logic store, err_next, accept;
  logic [FEAT_W-1:0] t0, t1, t2;
  logic [1:0] code;

  assign accept = s_valid & s_ready;

  // Thresholds are selected by the slot the current beat will land in.
  always_comb begin
    t0 = THRESH[TW*int'(idx) +: FEAT_W];
    t1 = THRESH[TW*int'(idx) + FEAT_W +: FEAT_W];
    t2 = THRESH[TW*int'(idx) + 2*FEAT_W +: FEAT_W];
    code = {1'b0, (s_data >= t0)} + {1'b0, (s_data >= t1)} + {1'b0, (s_data >= t2)};
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    store      = 1'b0;
    err_next   = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (idx == 3'd7) begin
            idx_next = 3'd0;
            if (s_last) begin
              store      = 1'b1;
              state_next = HOLD;
            end else begin
              err_next   = 1'b1;
              state_next = RESYNC;
            end
          end else if (s_last) begin
            idx_next = 3'd0;
            err_next = 1'b1;
          end else begin
            store    = 1'b1;
            idx_next = idx + 3'd1;
          end
        end
      end
      HOLD: begin
        if (m_ready) state_next = COLLECT;
      end
      RESYNC: begin
        if (accept && s_last) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // s_ready and m_valid are registered from the next state so neither has a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      idx     <= 3'd0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      s_ready <= (state_next != HOLD);
      m_valid <= (state_next == HOLD);
      err_len <= err_next;
      if (store) m_data[2*int'(idx) +: 2] <= code;
    end
  end

`ifdef TNN_ENC_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_len && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tnn_feature_encoder.sv
// Self-checking bench for tnn_feature_encoder: directed test-plan steps plus randomized vectors
// compared every cycle against a queue-based model of the beat/vector protocol.
module tb_tnn_feature_encoder;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        err_len;
`ifdef TNN_ENC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs should be at the current sampling point.
  logic        m_rdy;
  logic        m_hold;
  logic        m_err;
  logic        m_resync;
  logic [15:0] m_vec;
  int          m_cnt;
  int          beats[$];
  int          stim[$];

  tnn_feature_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
`ifdef TNN_ENC_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] quant(input int x);
    int c;
    c = 0;
    if (x >= 64)  c++;
    if (x >= 128) c++;
    if (x >= 192) c++;
    return 2'(c);
  endfunction

  function automatic logic [15:0] pack_beats();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = quant(beats[i]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model, step the clock.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic mr);
    logic acc, xfer, new_err;
    checkOutput("s_ready", {15'd0, s_ready}, {15'd0, m_rdy});
    checkOutput("m_valid", {15'd0, m_valid}, {15'd0, m_hold});
    checkOutput("err_len", {15'd0, err_len}, {15'd0, m_err});
    if (m_hold) checkOutput("m_data", m_data, m_vec);
`ifdef TNN_ENC_ERRCNT_EN
    checkOutput("err_cnt", {8'd0, err_cnt}, 16'(m_cnt));
`endif
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    acc     = v && m_rdy;
    xfer    = m_hold && mr;
    new_err = 1'b0;
    if (xfer) m_hold = 1'b0;
    if (acc) begin
      if (m_resync) begin
        if (l) m_resync = 1'b0;
      end else begin
        beats.push_back(int'(d));
        if (l) begin
          if (beats.size() == 8) begin
            m_vec  = pack_beats();
            m_hold = 1'b1;
          end else begin
            new_err = 1'b1;
          end
          beats.delete();
        end else if (beats.size() == 8) begin
          new_err  = 1'b1;
          m_resync = 1'b1;
          beats.delete();
        end
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
    m_err = new_err;
    m_rdy = !m_hold;
    @(posedge clk);
    #1;
  endtask

  task automatic sendStim(input logic mr);
    int b;
    int guard;
    logic acc;
    b = 0;
    guard = 0;
    while (b < stim.size()) begin
      acc = m_rdy;
      applyStimulus(1'b1, 8'(stim[b]), (b == stim.size() - 1), mr);
      if (acc) b++;
      guard++;
      if (guard > 200) begin
        total++;
        bad++;
        $display("[TB] FAIL send_timeout observed=%0d beats expected=%0d beats", b, stim.size());
        break;
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_m_valid", {15'd0, m_valid}, 16'd0);
    checkOutput("rst_m_data", m_data, 16'd0);
    checkOutput("rst_s_ready", {15'd0, s_ready}, 16'd0);
    checkOutput("rst_err_len", {15'd0, err_len}, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_s_ready", {15'd0, s_ready}, 16'd0);
    rst      = 1'b0;
    m_rdy    = 1'b0;
    m_hold   = 1'b0;
    m_err    = 1'b0;
    m_resync = 1'b0;
    m_vec    = '0;
    m_cnt    = 0;
    beats.delete();
  endtask

  task automatic loadRamp();
    stim = '{0, 63, 64, 127, 128, 191, 192, 255};
  endtask

  initial begin
    int len, b, guard;
    logic v, acc;
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    #2;
    doReset();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("ready_after_reset", {15'd0, s_ready}, 16'd1);

    // Quantization and packing.
    loadRamp();
    sendStim(1'b1);
    checkOutput("ramp_valid", {15'd0, m_valid}, 16'd1);
    checkOutput("ramp_data", m_data, 16'hFA50);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // Backpressure.
    loadRamp();
    sendStim(1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_data", m_data, 16'hFA50);
      applyStimulus(1'b1, 8'd33, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("bp_ready_rise", {15'd0, s_ready}, 16'd1);

    // Short vector, then an all-255 vector.
    stim = '{10, 20, 30};
    sendStim(1'b1);
    checkOutput("short_err", {15'd0, err_len}, 16'd1);
    stim = '{255, 255, 255, 255, 255, 255, 255, 255};
    sendStim(1'b1);
    checkOutput("ffff_data", m_data, 16'hFFFF);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // Long vector: error after beat 8, beats 9-10 dropped.
    stim = '{1, 2, 3, 4, 5, 6, 7, 8, 200, 210};
    sendStim(1'b1);
    checkOutput("long_no_valid", {15'd0, m_valid}, 16'd0);
    loadRamp();
    sendStim(1'b1);
    checkOutput("after_long_data", m_data, 16'hFA50);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-vector, then during HOLD.
    stim = '{200, 200, 200, 200, 200};
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd200, 1'b0, 1'b1);
    doReset();
    loadRamp();
    sendStim(1'b1);
    checkOutput("post_rst_data", m_data, 16'hFA50);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    stim = '{255, 255, 255, 255, 255, 255, 255, 255};
    sendStim(1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    doReset();
    loadRamp();
    sendStim(1'b1);
    checkOutput("post_hold_rst_data", m_data, 16'hFA50);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

`ifdef TNN_ENC_ERRCNT_EN
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("err_cnt_sat", {8'd0, err_cnt}, 16'd255);
`endif

    // Randomized vectors with gaps, occasional malformed lengths and random backpressure.
    for (int n = 0; n < 40; n++) begin
      len = ($urandom % 5 == 0) ? int'($urandom_range(1, 11)) : 8;
      b = 0;
      guard = 0;
      while (b < len && guard < 500) begin
        v = ($urandom % 4) != 0;
        acc = v && m_rdy;
        applyStimulus(v, 8'($urandom), (b == len - 1), ($urandom % 3) != 0);
        if (acc) b++;
        guard++;
      end
      if (b < len) begin
        total++;
        bad++;
        $display("[TB] FAIL rand_timeout observed=%0d beats expected=%0d beats", b, len);
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
